// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, BCD limits and small helpers
// used by the score keeper, display multiplexer and screen printer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DEAD    = 2'd2
    } game_state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Two BCD digits to binary (0..99).
    function automatic logic [6:0] bcd2_to_bin(input logic [7:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

    // Number of set bits in a 3-bit vector (0..3).
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/bcd_add4.sv
// Four-digit packed-BCD adder with a small (0..3) increment. A carry out of the
// thousands digit saturates the result at 9999 instead of wrapping.
module bcd_add4
    import game_pkg::*;
(
    input  logic [15:0] a,
    input  logic [1:0]  inc,
    output logic [15:0] sum
);

    logic [15:0] sum_raw;
    logic [4:0]  digit_sum;
    logic [1:0]  carry;

    // Ripple the increment through the digits, wrapping each digit at ten.
    always_comb begin
        sum_raw   = '0;
        digit_sum = '0;
        carry     = inc;
        for (int i = 0; i < 4; i++) begin
            digit_sum = {1'b0, a[4*i +: 4]} + {3'b000, carry};
            if (digit_sum >= 5'd10) begin
                sum_raw[4*i +: 4] = 4'(digit_sum - 5'd10);
                carry             = 2'd1;
            end else begin
                sum_raw[4*i +: 4] = digit_sum[3:0];
                carry             = 2'd0;
            end
        end
        sum = (carry != 2'd0) ? BCD_MAX : sum_raw;
    end

endmodule

// File: rtl/score_keeper.sv
// Game state and scoring: tracks IDLE/PLAYING/DEAD, accumulates the BCD score
// from wave pass pulses, keeps the best score and derives the wave speed divisor.
module score_keeper
    import game_pkg::*;
#(
    parameter logic [25:0] SPEED_BASE = 26'd2_500_000,
    parameter logic [25:0] SPEED_STEP = 26'd100_000,
    parameter logic [25:0] SPEED_MIN  = 26'd500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btns,
    input  logic [2:0]  wave_pass,
    input  logic [2:0]  death,
    output logic [15:0] current_score,
    output logic [15:0] high_score,
    output logic        playing,
    output logic        dead,
    output logic        new_high,
    output logic [25:0] speed_ctrl
);

    game_state_t state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] high_q, high_d;
    logic        new_high_q, new_high_d;
    logic [25:0] speed_q, speed_d;
    logic        btns_q;
    logic        armed_q;
    logic        start_pulse;

    logic [1:0]  inc;
    logic [15:0] score_inc;
    logic [6:0]  hundreds;
    logic [25:0] speed_drop;
    logic [25:0] speed_target;

    // A button held through reset must be released once before it can start a
    // game, otherwise the edge detector would fire as soon as reset drops.
    assign start_pulse = btns & ~btns_q & armed_q;

    assign inc = popcount3(wave_pass);

    bcd_add4 u_bcd_add4 (
        .a   (score_q),
        .inc (inc),
        .sum (score_inc)
    );

    // Speed divisor target from the hundreds of the current score, floored.
    always_comb begin
        hundreds     = bcd2_to_bin(score_q[15:8]);
        speed_drop   = 26'(hundreds) * SPEED_STEP;
        speed_target = (speed_drop >= SPEED_BASE - SPEED_MIN) ? SPEED_MIN
                                                              : SPEED_BASE - speed_drop;
    end

    // Next-state, scoring and high-score update.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        speed_d    = speed_target;
        unique case (state_q)
            ST_IDLE, ST_DEAD: begin
                if (start_pulse) begin
                    state_d    = ST_PLAYING;
                    score_d    = '0;
                    new_high_d = 1'b0;
                    speed_d    = SPEED_BASE;
                end
            end
            ST_PLAYING: begin
                // Death wins over a same-cycle pass: no increment.
                if (|death) begin
                    state_d = ST_DEAD;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else begin
                    score_d = score_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            speed_q    <= SPEED_BASE;
            btns_q     <= 1'b0;
            armed_q    <= ~btns;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            speed_q    <= speed_d;
            btns_q     <= btns;
            armed_q    <= armed_q | ~btns;
        end
    end

    assign current_score = score_q;
    assign high_score    = high_q;
    assign new_high      = new_high_q;
    assign speed_ctrl    = speed_q;
    assign playing       = (state_q == ST_PLAYING);
    assign dead          = (state_q == ST_DEAD);

endmodule
